// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared types for the register-file writeback arbiter.
//   REG_ID_W / DATA_W / NUM_REGS : register-file geometry.
//   SEQ_MAX_W : storage width of the age tag. Tags narrower than this are kept
//               left-aligned, so an 8-bit modular compare gives the same answer
//               as a compare at the narrower width.
//   wb_entry_t : one queued write {reg_id, data, seq}.
//   src_e      : which source FIFO is popped.
//   seq_older  : modular age compare; true when a was accepted before b.
package regfile_wb_pkg;
  localparam int REG_ID_W  = 4;
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 16;
  localparam int SEQ_MAX_W = 8;

  typedef struct packed {
    logic [REG_ID_W-1:0]  reg_id;
    logic [DATA_W-1:0]    data;
    logic [SEQ_MAX_W-1:0] seq;
  } wb_entry_t;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  function automatic logic seq_older(input logic [SEQ_MAX_W-1:0] a,
                                     input logic [SEQ_MAX_W-1:0] b);
    logic [SEQ_MAX_W-1:0] diff;
    diff = a - b;
    return diff[SEQ_MAX_W-1];
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bundles the two writeback request ports and the
// register-file write port.
//   a_valid/a_ready/a_reg/a_data : port A (load return) request handshake.
//   b_valid/b_ready/b_reg/b_data : port B (ALU result) request handshake.
//   wr_en/wr_reg/wr_data         : register-file WriteReg/DstReg/DstData.
//   pending                      : per-register write-in-flight vector.
// master = requesting side, slave = arbiter.
interface regfile_wb_arbiter_if;
  import regfile_wb_pkg::*;

  logic                a_valid;
  logic                a_ready;
  logic [REG_ID_W-1:0] a_reg;
  logic [DATA_W-1:0]   a_data;
  logic                b_valid;
  logic                b_ready;
  logic [REG_ID_W-1:0] b_reg;
  logic [DATA_W-1:0]   b_data;
  logic                wr_en;
  logic [REG_ID_W-1:0] wr_reg;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, pending
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, pending
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry circular buffer of writeback entries.
//   clk, rst_n      : clock, async active-low reset (pointers/count only).
//   push, din       : enqueue (caller guarantees not full).
//   pop             : dequeue head (caller guarantees not empty).
//   head            : oldest entry.
//   empty, count    : occupancy, from registered state.
//   ent_vld/ent_reg : per-slot valid flag and destination register, used to
//                     build the pending vector.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  wb_entry_t                   din,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0]            ent_vld,
  output logic [DEPTH*REG_ID_W-1:0]   ent_reg
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset  = '0;
    ent_vld = '0;
    ent_reg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset     = PTR_W'(i) - rd_ptr;
      ent_vld[i] = ({1'b0, offset} < count);
      ent_reg[i*REG_ID_W +: REG_ID_W] = mem[i].reg_id;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between port A
// (load return) and port B (ALU result). Each port has a wb_fifo; heads drain
// one per cycle, oldest age tag first, into a registered output stage.
//   clk, rst_n : clock, async active-low reset.
//   bus        : regfile_wb_arbiter_if.slave (request ports, write port,
//                pending vector).
// Optional macro WB_BYPASS_EN: when both FIFOs are empty, a single accepted
// entry (A if both accept) loads the output stage directly on the accept edge.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEQ_W = $clog2(2*DEPTH)+1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  regfile_wb_arbiter_if.slave         bus
);
  localparam int CNT_W = $clog2(DEPTH)+1;
  localparam int SHIFT = SEQ_MAX_W - SEQ_W;

  logic                      rdy_en;
  logic [SEQ_W-1:0]          seq_cnt;
  logic [SEQ_W-1:0]          a_seq, b_seq;
  logic                      a_acc, b_acc, a_push, b_push, a_pop, b_pop;
  logic                      a_byp, b_byp, both_empty;
  logic                      a_empty, b_empty;
  logic [CNT_W-1:0]          a_cnt, b_cnt;
  logic [DEPTH-1:0]          a_vld, b_vld;
  logic [DEPTH*REG_ID_W-1:0] a_regs, b_regs;
  wb_entry_t                 a_din, b_din, a_head, b_head;
  src_e                      pop_src;

  logic                      wb_vld_p0;
  logic [REG_ID_W-1:0]       wb_reg_p0;
  logic [DATA_W-1:0]         wb_data_p0;
  logic                      wr_en_p1;
  logic [REG_ID_W-1:0]       wr_reg_p1;
  logic [DATA_W-1:0]         wr_data_p1;
  logic [NUM_REGS-1:0]       pend;

  // ---- accept stage: handshake, age tagging, bypass decision ----
  assign bus.a_ready = rdy_en && (a_cnt != CNT_W'(DEPTH));
  assign bus.b_ready = rdy_en && (b_cnt != CNT_W'(DEPTH));
  assign a_acc       = bus.a_valid & bus.a_ready;
  assign b_acc       = bus.b_valid & bus.b_ready;
  assign both_empty  = a_empty & b_empty;

  assign a_seq = seq_cnt;
  assign b_seq = seq_cnt + SEQ_W'(a_acc);

  always_comb begin
    a_din        = '0;
    a_din.reg_id = bus.a_reg;
    a_din.data   = bus.a_data;
    a_din.seq    = SEQ_MAX_W'(a_seq) << SHIFT;
    b_din        = '0;
    b_din.reg_id = bus.b_reg;
    b_din.data   = bus.b_data;
    b_din.seq    = SEQ_MAX_W'(b_seq) << SHIFT;
  end

`ifdef WB_BYPASS_EN
  assign a_byp = both_empty & a_acc;
  assign b_byp = both_empty & b_acc & ~a_acc;
`else
  assign a_byp = 1'b0;
  assign b_byp = 1'b0;
`endif

  assign a_push = a_acc & ~a_byp;
  assign b_push = b_acc & ~b_byp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en  <= 1'b0;
      seq_cnt <= '0;
    end else begin
      rdy_en  <= 1'b1;
      seq_cnt <= seq_cnt + SEQ_W'(a_acc) + SEQ_W'(b_acc);
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push(a_push), .din(a_din), .pop(a_pop),
    .head(a_head), .empty(a_empty), .count(a_cnt),
    .ent_vld(a_vld), .ent_reg(a_regs)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push(b_push), .din(b_din), .pop(b_pop),
    .head(b_head), .empty(b_empty), .count(b_cnt),
    .ent_vld(b_vld), .ent_reg(b_regs)
  );

  // ---- arbitration stage: pick the older head, select output entry ----
  always_comb begin
    pop_src = SRC_A;
    if (!b_empty && (a_empty || seq_older(b_head.seq, a_head.seq)))
      pop_src = SRC_B;
  end

  assign a_pop = ~a_empty & (pop_src == SRC_A);
  assign b_pop = ~b_empty & (pop_src == SRC_B);

  always_comb begin
    wb_vld_p0  = 1'b1;
    wb_reg_p0  = a_head.reg_id;
    wb_data_p0 = a_head.data;
    if (a_byp) begin
      wb_reg_p0  = bus.a_reg;
      wb_data_p0 = bus.a_data;
    end else if (b_byp) begin
      wb_reg_p0  = bus.b_reg;
      wb_data_p0 = bus.b_data;
    end else if (a_pop) begin
      wb_reg_p0  = a_head.reg_id;
      wb_data_p0 = a_head.data;
    end else if (b_pop) begin
      wb_reg_p0  = b_head.reg_id;
      wb_data_p0 = b_head.data;
    end else begin
      wb_vld_p0  = 1'b0;
    end
  end

  // ---- output stage: register-file write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_p1   <= 1'b0;
      wr_reg_p1  <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= wb_vld_p0 && (wb_reg_p0 != '0);
      if (wb_vld_p0) begin
        wr_reg_p1  <= wb_reg_p0;
        wr_data_p1 <= wb_data_p0;
      end
    end
  end

  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_reg  = wr_reg_p1;
  assign bus.wr_data = wr_data_p1;

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i]) pend[a_regs[i*REG_ID_W +: REG_ID_W]] = 1'b1;
      if (b_vld[i]) pend[b_regs[i*REG_ID_W +: REG_ID_W]] = 1'b1;
    end
    if (wr_en_p1) pend[wr_reg_p1] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.pending = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rf [16];
  int tests = 0;
  int fails = 0;
  int writes = 0;
  int accepts = 0;
  int ready_drop = 0;
  int w0;
  int a0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Drive both ports; record every accepted non-r0 write in acceptance order.
  task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic bv, input logic [3:0] br, input logic [15:0] bd);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    #1;
    if (rst_n && av && !bus.a_ready) ready_drop = 1;
    if (rst_n && bv && !bus.b_ready) ready_drop = 1;
    if (rst_n && av && bus.a_ready && ar != 4'd0) begin sb.push_back({ar, ad}); accepts++; end
    if (rst_n && bv && bus.b_ready && br != 4'd0) begin sb.push_back({br, bd}); accepts++; end
  endtask

  // Scoreboard: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.wr_en) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", bus.wr_en, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("wr_reg", bus.wr_reg, e.r);
        chk("wr_data", bus.wr_data, e.d);
      end
      rf[bus.wr_reg] = bus.wr_data;
      writes++;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    bus.a_valid = 1'b1; bus.a_reg = 4'd1; bus.a_data = 16'h0;
    bus.b_valid = 1'b0; bus.b_reg = 4'd0; bus.b_data = 16'h0;

    // Reset with a request held
    repeat (2) cyc();
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_pending", bus.pending, 16'h0);
    bus.a_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("rel_a_ready", bus.a_ready, 1'b1);
    chk("rel_b_ready", bus.b_ready, 1'b1);

    // Single write
    drive(1, 4'd5, 16'h1234, 0, 4'd0, 16'h0);
    chk("single_pend_pre", bus.pending[5], 1'b0);
    cyc();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      chk("single_wr_en", bus.wr_en, (c == LAT));
      chk("single_pend5", bus.pending[5], (c <= LAT));
      if (c == LAT) begin
        chk("single_wr_reg", bus.wr_reg, 4'd5);
        chk("single_wr_data", bus.wr_data, 16'h1234);
      end
      cyc();
    end

    // Same-cycle conflict on r3
    drive(1, 4'd3, 16'hAAAA, 1, 4'd3, 16'hBBBB);
    cyc();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    for (int c = 1; c <= LAT + 2; c++) begin
      chk("conf_pend3", bus.pending[3], (c <= LAT + 1));
      if (c == LAT)     chk("conf_first", {15'd0, bus.wr_en, bus.wr_data}, {15'd0, 1'b1, 16'hAAAA});
      if (c == LAT + 1) chk("conf_second", {15'd0, bus.wr_en, bus.wr_data}, {15'd0, 1'b1, 16'hBBBB});
      cyc();
    end

    // Age order across ports on r7
    drive(0, 4'd0, 16'h0, 1, 4'd7, 16'h0001);
    cyc();
    drive(1, 4'd7, 16'h0002, 0, 4'd0, 16'h0);
    cyc();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    repeat (4) cyc();
    chk("age_r7_final", rf[7], 16'h0002);
    chk("age_drained", sb.size(), 0);

    // Both ports streaming
    w0 = writes;
    a0 = accepts;
    ready_drop = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(1 + i % 7), 16'(16'hA000 + i), 1, 4'(8 + i % 7), 16'(16'hB000 + i));
      cyc();
      if (i >= 2) chk("stream_wr_en", bus.wr_en, 1'b1);
    end
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    repeat (10) cyc();
    chk("stream_ready_drop", ready_drop, 1);
    chk("stream_drained", sb.size(), 0);
    chk("stream_count", writes - w0, accepts - a0);
    chk("stream_pending_idle", bus.pending, 16'h0);

    // Register 0 write is consumed silently
    w0 = writes;
    drive(1, 4'd0, 16'hFFFF, 0, 4'd0, 16'h0);
    chk("r0_accept", bus.a_ready, 1'b1);
    cyc();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      chk("r0_wr_en", bus.wr_en, 1'b0);
      chk("r0_pend0", bus.pending[0], 1'b0);
      cyc();
    end
    chk("r0_no_write", writes - w0, 0);

    // Reset while entries are queued
    drive(1, 4'd9, 16'h0909, 1, 4'd10, 16'h0A0A);
    cyc();
    drive(1, 4'd11, 16'h0B0B, 1, 4'd12, 16'h0C0C);
    cyc();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    chk("mid_pending_busy", (bus.pending != 16'h0), 1'b1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_pending", bus.pending, 16'h0);
    chk("mid_rst_wr_en", bus.wr_en, 1'b0);
    chk("mid_rst_a_ready", bus.a_ready, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_rel_a_ready", bus.a_ready, 1'b1);
    repeat (3) cyc();
    chk("mid_idle_pending", bus.pending, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: port A (memory load return) and port B (ALU/EX result).
- Each source gets a small FIFO with a valid/ready handshake. Queued writes drain one per cycle in strict acceptance order, and the block drives WriteReg/DstReg/DstData into the register file.
- A per-register pending vector lets hazard logic stall readers of registers that still have a write in flight.

Parameters:
- DEPTH, 2, entries per source FIFO (power of 2, ≥2).
- SEQ_W, $clog2(2*DEPTH)+1, width of the age tag attached to each accepted entry.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A FIFO can accept.
- a_reg  in  4  port A destination register ID.
- a_data  in  16  port A write data.
- b_valid  in  1  port B write request.
- b_ready  out  1  port B FIFO can accept.
- b_reg  in  4  port B destination register ID.
- b_data  in  16  port B write data.
- wr_en  out  1  drives register file WriteReg.
- wr_reg  out  4  drives DstReg.
- wr_data  out  16  drives DstData.
- pending  out  16  bit i=1 while any queued or output-stage write targets register i.

Behaviour:
- Reset (rst_n low, async):
  - Both FIFOs empty; entries discarded.
  - Sequence counter = 0.
  - wr_en=0, wr_reg=0, wr_data=0, pending=0.
  - a_ready=b_ready=0 while rst_n is low; both go to 1 in the first cycle after release.
- Accept: a transfer happens on a rising edge with x_valid & x_ready.
  - x_ready = !full, from the registered count. No pop-through when full: a full FIFO holds ready low even if it pops that cycle.
  - Each accepted entry stores {reg, data, seq}. The global seq counter increments by 1 per accept, or 2 if both ports accept, and wraps mod 2^SEQ_W.
  - Same-cycle accepts: A takes seq, B takes seq+1.
- Register 0: a request with reg=0 is accepted and queued normally. When it drains, wr_en stays 0 (r0 is hardwired zero), and it never sets pending[0].
- Arbitration, evaluated each cycle over non-empty heads:
  - One head only: pop it.
  - Both heads: pop the one with the older seq, using a modular compare on the seq difference MSB.
  - At most one pop per cycle. The register file never back-pressures.
- Output stage:
  - Registered; loads on every edge.
  - On a pop: wr_en = (reg != 0), wr_reg/wr_data = entry fields.
  - No pop: wr_en=0, wr_reg/wr_data hold their previous values.
- Latency: accept at edge k, then head selection after edge k, then wr_en high in the cycle after edge k+1 (2 cycles minimum). Queueing adds 1 cycle per older entry.
- pending: combinational OR of the one-hot decode of every valid FIFO entry's reg, plus wr_reg while wr_en=1. Bit 0 is forced to 0.
- Ordering guarantee: two writes to the same register retire in acceptance order, whichever ports carried them.
- Throughput: sustained 1 write/cycle. If both ports stream, each port is throttled to an average of 1/2 per cycle via ready.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when both FIFOs are empty and exactly one port transfers, the entry skips the FIFO and loads the output stage on that same edge. Minimum latency is then 1 cycle and the seq counter still advances.
  - If both ports transfer into empty FIFOs, A bypasses and B is queued.
- Undefined: every entry passes through its FIFO, giving 2-cycle minimum latency.

Decomposition:
- Package regfile_wb_pkg:
  - REG_ID_W=4, DATA_W=16, NUM_REGS=16.
  - wb_entry_t struct {reg_id, data, seq}.
  - src_e enum {SRC_A, SRC_B}.
  - Function seq_older(a,b) for the modular compare.
- Sub-module wb_fifo, instantiated twice:
  - DEPTH-entry circular buffer with push/pop, full/empty, count.
  - Exposes the head entry and a flattened per-entry valid+reg vector for pending generation.

Test Plan:
- Reset: drive a_valid=1 with rst_n low → a_ready=0, wr_en=0, pending=0. Release → a_ready=1 the next cycle.
- Single write: A writes reg 5 data 0x1234 at edge k → pending[5]=1 from edge k; wr_en=1, wr_reg=5, wr_data=0x1234 after edge k+1; pending[5]=0 after edge k+2. With WB_BYPASS_EN: wr_en after edge k.
- Same-cycle conflict: A(reg 3, 0xAAAA) and B(reg 3, 0xBBBB) accepted together → two consecutive writes, 0xAAAA then 0xBBBB; pending[3] stays 1 until after the second.
- Age order across ports: B(reg 7, 0x0001) at edge k, A(reg 7, 0x0002) at edge k+1 → B's write retires first, final r7 value 0x0002.
- Full/backpressure: DEPTH=2, hold a_valid=b_valid=1 for 8 cycles → ready drops when a FIFO is full, no beat lost or duplicated, wr_en=1 every cycle once primed, seq wrap exercised.
- Reg 0: A writes reg 0 data 0xFFFF → entry consumed, wr_en stays 0, pending[0] never 1. Asserting rst_n low mid-queue clears pending and wr_en immediately.
